// File: rtl/axis_sample_fifo_if.sv
// AXI-Stream beat channel (tdata/tvalid/tready) shared by the sample producer,
// the sample FIFO and the stream reader.
interface axis_sample_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_sample_fifo.sv
// First-word-fall-through AXI-Stream sample FIFO with fill level reporting.
// Define AXIS_FIFO_DROP_EN to never stall upstream and count dropped beats instead.
module axis_sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_sample_fifo_if.slave     s_axis,
    axis_sample_fifo_if.master    m_axis,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    input  logic                  clear_overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int AW    = (DEPTH_LOG2 == 0) ? 1 : DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  ready_en_q;
    logic                  full, empty;
    logic                  wr_fire, rd_fire;
    logic [AW-1:0]         wr_addr, rd_addr;

    assign full    = (count_q == DEPTH_P);
    assign empty   = (count_q == '0);
    assign rd_fire = !empty && m_axis.tready;
    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

`ifdef AXIS_FIFO_DROP_EN
    logic        drop;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    // Upstream is never stalled; a full FIFO only accepts when a read frees a slot.
    assign s_axis.tready = ready_en_q;
    assign wr_fire       = s_axis.tvalid && ready_en_q && (!full || rd_fire);
    assign drop          = s_axis.tvalid && ready_en_q && full && !rd_fire;

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)
                drop_count_d = 16'd1;
            else if (drop_count_q != 16'hFFFF)
                drop_count_d = drop_count_q + 16'd1;
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`else
    logic unused_clear_overflow;

    assign s_axis.tready         = ready_en_q && !full;
    assign wr_fire               = s_axis.tvalid && ready_en_q && !full;
    assign overflow              = 1'b0;
    assign drop_count            = 16'd0;
    assign unused_clear_overflow = clear_overflow;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire)
            wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
        if (rd_fire)
            rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    // Ready-enable comes up on the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage holds no reset; occupancy alone decides which entries are live.
    always_ff @(posedge aclk) begin
        if (wr_fire)
            mem_q[wr_addr] <= s_axis.tdata;
    end

    assign m_axis.tdata  = mem_q[rd_addr];
    assign m_axis.tvalid = !empty;
    assign fill_level    = count_q;
endmodule

// File: tb/tb_axis_sample_fifo.sv
// Randomised and directed bench for axis_sample_fifo (DATA_WIDTH 8, depth 4),
// checked every cycle against a queue model; honours AXIS_FIFO_DROP_EN.
module tb_axis_sample_fifo;
    localparam int DW    = 8;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          clear_overflow = 1'b0;
    logic [DL2:0]  fill_level;
    logic          overflow;
    logic [15:0]   drop_count;

    axis_sample_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    axis_sample_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    axis_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a queue of stored beats plus the ready-enable and drop status.
    logic [DW-1:0] mq[$];
    bit            m_en  = 1'b0;
    bit            m_ovf = 1'b0;
    int            m_dc  = 0;
    bit            md_rd, md_acc, md_drp, md_full;
`ifdef AXIS_FIFO_DROP_EN
    localparam bit DROP_BUILD = 1'b1;
`else
    localparam bit DROP_BUILD = 1'b0;
`endif

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mq.delete();
            m_en  = 1'b0;
            m_ovf = 1'b0;
            m_dc  = 0;
        end else begin
            md_full = (mq.size() == DEPTH);
            md_rd   = (mq.size() != 0) && (m_if.tready == 1'b1);
            if (DROP_BUILD) begin
                md_acc = s_if.tvalid && m_en && (!md_full || md_rd);
                md_drp = s_if.tvalid && m_en && md_full && !md_rd;
            end else begin
                md_acc = s_if.tvalid && m_en && !md_full;
                md_drp = 1'b0;
            end
            if (md_rd)  void'(mq.pop_front());
            if (md_acc) mq.push_back(s_if.tdata);
            if (md_drp) begin
                m_ovf = 1'b1;
                m_dc  = clear_overflow ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
            end else if (clear_overflow) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end
            m_en = 1'b1;
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge aclk) begin
        if (cmp_on) begin
            check("s_tready", {31'd0, s_if.tready},
                  {31'd0, m_en && (DROP_BUILD || mq.size() < DEPTH)});
            check("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, mq.size() != 0});
            check("fill_level", {29'd0, fill_level}, mq.size());
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("drop_count", {16'd0, drop_count}, m_dc);
            if (mq.size() != 0)
                check("m_tdata", {24'd0, m_if.tdata}, {24'd0, mq[0]});
        end
    end

    // Inputs change on the falling edge; one call advances exactly one rising edge.
    task automatic cyc();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        #1 aresetn = 1'b0;
        cmp_on = 1'b1;

        // Reset held for three edges, then released between edges.
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(negedge aclk);
        check("rst_tready_low", {31'd0, s_if.tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_fill", {29'd0, fill_level}, 32'd0);
        cyc();
        check("rst_tready_high", {31'd0, s_if.tready}, 32'd1);
        $display("reset released, s_tready=%0b", s_if.tready);

        // Single beat held while the reader stalls.
        s_if.tvalid = 1'b1; s_if.tdata = 8'h35;
        cyc();
        s_if.tvalid = 1'b0;
        check("single_tvalid", {31'd0, m_if.tvalid}, 32'd1);
        check("single_tdata", {24'd0, m_if.tdata}, 32'h35);
        check("single_fill", {29'd0, fill_level}, 32'd1);
        cyc(); cyc();
        check("single_hold", {24'd0, m_if.tdata}, 32'h35);
        m_if.tready = 1'b1;
        cyc();
        m_if.tready = 1'b0;
        check("single_drain", {29'd0, fill_level}, 32'd0);
        $display("single beat 0x35 done");

        // Fill to depth, offer one more, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 8'(i);
            cyc();
        end
        s_if.tdata = 8'h05;
        check("fill_full", {29'd0, fill_level}, 32'd4);
        check("fill_tready", {31'd0, s_if.tready}, {31'd0, DROP_BUILD});
        cyc();
        s_if.tvalid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("fill_order", {24'd0, m_if.tdata}, i);
            m_if.tready = 1'b1;
            cyc();
            if (i == 1) check("fill_tready_back", {31'd0, s_if.tready}, 32'd1);
        end
        m_if.tready = 1'b0;
        check("fill_empty", {29'd0, fill_level}, 32'd0);
        $display("fill/drain of 0x01..0x04 done");

        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;

        // Streaming with both sides always ready.
        for (int i = 0; i < 20; i++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 8'(8'h10 + i);
            m_if.tready = 1'b1;
            cyc();
            check("stream_fill", {29'd0, fill_level}, 32'd1);
            check("stream_data", {24'd0, m_if.tdata}, 32'h10 + i);
        end
        s_if.tvalid = 1'b0;
        cyc();
        m_if.tready = 1'b0;
        check("stream_end", {29'd0, fill_level}, 32'd0);
        $display("streaming of 20 beats done");

        // Overfill by two beats with the reader stalled.
        for (int i = 0; i < 6; i++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 8'(8'hA0 + i);
            cyc();
        end
        s_if.tvalid = 1'b0;
        check("drop_ovf", {31'd0, overflow}, {31'd0, DROP_BUILD});
        check("drop_cnt", {16'd0, drop_count}, DROP_BUILD ? 32'd2 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("drop_readout", {24'd0, m_if.tdata}, 32'hA0 + i);
            m_if.tready = 1'b1;
            cyc();
        end
        m_if.tready = 1'b0;
        check("drop_empty", {31'd0, m_if.tvalid}, 32'd0);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_cnt", {16'd0, drop_count}, 32'd0);
        $display("overfill 0xA0..0xA5 done, drop build=%0b", DROP_BUILD);

        // Asynchronous reset pulse with three beats stored.
        for (int i = 0; i < 3; i++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 8'(8'h50 + i);
            cyc();
        end
        s_if.tvalid = 1'b0;
        check("mid_fill", {29'd0, fill_level}, 32'd3);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("mid_rst_fill", {29'd0, fill_level}, 32'd0);
        check("mid_rst_tready", {31'd0, s_if.tready}, 32'd0);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        @(negedge aclk);
        cyc();
        check("mid_ready_back", {31'd0, s_if.tready}, 32'd1);
        s_if.tvalid = 1'b1; s_if.tdata = 8'h77;
        cyc();
        s_if.tvalid = 1'b0;
        check("mid_tvalid", {31'd0, m_if.tvalid}, 32'd1);
        check("mid_tdata", {24'd0, m_if.tdata}, 32'h77);
        m_if.tready = 1'b1;
        cyc();
        m_if.tready = 1'b0;
        check("mid_empty", {29'd0, fill_level}, 32'd0);
        $display("mid-stream reset and 0x77 readback done");

        // Random traffic: slow reader first to exercise full, then a fast one.
        for (int i = 0; i < 600; i++) begin
            s_if.tvalid    = ($urandom_range(0, 3) != 0);
            s_if.tdata     = 8'($urandom);
            m_if.tready    = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 40) == 0);
            cyc();
        end
        s_if.tvalid = 1'b0; m_if.tready = 1'b0; clear_overflow = 1'b0;
        cyc();
        $display("random traffic of 600 cycles done");

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
